// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS-subset opcode, funct and ALU encodings shared by the decode stage
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_NOR = 4'd5,
    ALU_LUI = 4'd6
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src_imm;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - ID/EX pipeline register bundle with valid/ready handshake
interface id_stage_if #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 4
);
  logic                ex_valid;
  logic                ex_ready;
  logic [DATA_W-1:0]   ex_pc;
  logic [DATA_W-1:0]   ex_rs_data;
  logic [DATA_W-1:0]   ex_rt_data;
  logic [DATA_W-1:0]   ex_imm;
  logic [REG_AW-1:0]   ex_dest;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic                ex_alu_src_imm;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic                ex_illegal;

  modport master (
    output ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_dest, ex_alu_op,
           ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_dest, ex_alu_op,
           ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal,
    output ex_ready
  );
endinterface

// File: rtl/id_decoder.sv
// rtl/id_decoder.sv - combinational instruction decode: control, immediate, dest, source use
module id_decoder
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [DATA_W-1:0] instr,
  output ctrl_t             ctrl,
  output logic [DATA_W-1:0] imm,
  output logic [REG_AW-1:0] dest,
  output logic              uses_rs,
  output logic              uses_rt
);
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic              unused_shamt;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign imm_sext     = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign imm_zext     = {{(DATA_W-16){1'b0}}, instr[15:0]};
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    imm         = imm_sext;
    dest        = instr[20:16];
    uses_rs     = 1'b0;
    uses_rt     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest           = instr[15:11];
        uses_rs        = 1'b1;
        uses_rt        = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          FN_NOR:  ctrl.alu_op = ALU_NOR;
          default: begin
            ctrl.illegal   = 1'b1;
            ctrl.reg_write = 1'b0;
            uses_rs        = 1'b0;
            uses_rt        = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: begin
        uses_rs          = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.mem_read    = (opcode == OP_LW);
        case (opcode)
          OP_SLTI: ctrl.alu_op = ALU_SLT;
          OP_ANDI: begin ctrl.alu_op = ALU_AND; imm = imm_zext; end
          OP_ORI:  begin ctrl.alu_op = ALU_OR;  imm = imm_zext; end
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_LUI: begin
        ctrl.alu_op      = ALU_LUI;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
        imm              = {instr[15:0], {(DATA_W-16){1'b0}}};
      end
      OP_SW: begin
        uses_rs          = 1'b1;
        uses_rt          = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_write   = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // Writes to $0 are discarded, so never advertise them downstream.
    if (dest == '0) ctrl.reg_write = 1'b0;
  end
endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: rf addressing, writeback bypass, load-use hazard, ID/EX register
module id_stage
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              id_ready,
  input  logic              flush,
  output logic [REG_AW-1:0] rf_read_addr_1,
  output logic [REG_AW-1:0] rf_read_addr_2,
  input  logic [DATA_W-1:0] rf_read_data_1,
  input  logic [DATA_W-1:0] rf_read_data_2,
  input  logic              wb_write_en,
  input  logic [REG_AW-1:0] wb_write_dest,
  input  logic [DATA_W-1:0] wb_write_data,
  id_stage_if.master        ex
);
  ctrl_t             dec_ctrl;
  logic [DATA_W-1:0] dec_imm;
  logic [REG_AW-1:0] dec_dest;
  logic              dec_uses_rs;
  logic              dec_uses_rt;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              adv;
  logic              hz;

  logic              ex_valid_q,   ex_valid_d;
  logic [DATA_W-1:0] ex_pc_q,      ex_pc_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
  logic [REG_AW-1:0] ex_dest_q,    ex_dest_d;
  ctrl_t             ex_ctrl_q,    ex_ctrl_d;

  id_decoder #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_dec (
    .instr   (if_instr),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .dest    (dec_dest),
    .uses_rs (dec_uses_rs),
    .uses_rt (dec_uses_rt)
  );

  assign rf_read_addr_1 = if_instr[25:21];
  assign rf_read_addr_2 = if_instr[20:16];

  // The register file writes at the same edge we sample, so forward the writeback value.
  function automatic logic [DATA_W-1:0] bypass(input logic [REG_AW-1:0] addr,
                                               input logic [DATA_W-1:0] rf_data);
    if (addr == '0)                                            return '0;
    else if (wb_write_en && wb_write_dest != '0 && wb_write_dest == addr) return wb_write_data;
    else                                                       return rf_data;
  endfunction

  assign rs_data = bypass(rf_read_addr_1, rf_read_data_1);
  assign rt_data = bypass(rf_read_addr_2, rf_read_data_2);

  assign adv = !ex_valid_q || ex.ex_ready;
  assign hz  = if_valid && ex_valid_q && ex_ctrl_q.mem_read && ex_dest_q != '0 &&
               ((dec_uses_rs && ex_dest_q == rf_read_addr_1) ||
                (dec_uses_rt && ex_dest_q == rf_read_addr_2));
  assign id_ready = flush || (adv && !hz);

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    ex_dest_d    = ex_dest_q;
    ex_ctrl_d    = ex_ctrl_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (adv && hz) begin
      ex_valid_d = 1'b0;
    end else if (adv && if_valid) begin
      ex_valid_d   = 1'b1;
      ex_pc_d      = if_pc;
      ex_rs_data_d = rs_data;
      ex_rt_data_d = rt_data;
      ex_imm_d     = dec_imm;
      ex_dest_d    = dec_dest;
      ex_ctrl_d    = dec_ctrl;
    end else if (adv) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_dest_q    <= '0;
      ex_ctrl_q    <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_dest_q    <= ex_dest_d;
      ex_ctrl_q    <= ex_ctrl_d;
    end
  end

  assign ex.ex_valid       = ex_valid_q;
  assign ex.ex_pc          = ex_pc_q;
  assign ex.ex_rs_data     = ex_rs_data_q;
  assign ex.ex_rt_data     = ex_rt_data_q;
  assign ex.ex_imm         = ex_imm_q;
  assign ex.ex_dest        = ex_dest_q;
  assign ex.ex_alu_op      = ALU_OP_W'(ex_ctrl_q.alu_op);
  assign ex.ex_alu_src_imm = ex_ctrl_q.alu_src_imm;
  assign ex.ex_reg_write   = ex_ctrl_q.reg_write;
  assign ex.ex_mem_read    = ex_ctrl_q.mem_read;
  assign ex.ex_mem_write   = ex_ctrl_q.mem_write;
  assign ex.ex_illegal     = ex_ctrl_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage with directed MIPS instruction vectors
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        flush;
  logic [4:0]  rf_read_addr_1;
  logic [4:0]  rf_read_addr_2;
  logic [31:0] rf_read_data_1;
  logic [31:0] rf_read_data_2;
  logic        wb_write_en;
  logic [4:0]  wb_write_dest;
  logic [31:0] wb_write_data;

  id_stage_if #(.DATA_W(32), .REG_AW(5), .ALU_OP_W(4)) ex_if ();

  id_stage #(.DATA_W(32), .REG_AW(5), .ALU_OP_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .flush          (flush),
    .rf_read_addr_1 (rf_read_addr_1),
    .rf_read_addr_2 (rf_read_addr_2),
    .rf_read_data_1 (rf_read_data_1),
    .rf_read_data_2 (rf_read_data_2),
    .wb_write_en    (wb_write_en),
    .wb_write_dest  (wb_write_dest),
    .wb_write_data  (wb_write_data),
    .ex             (ex_if)
  );

  always #5 clk = ~clk;

  // pc, rs, rt, imm, dest, alu_op, alu_src_imm, reg_write, mem_read, mem_write, illegal
  typedef logic [141:0] ev_t;
  typedef struct {
    ev_t v;
    bit  ctrl_only;
  } sb_t;

  localparam ev_t CTRL_MASK = 142'hF;
  sb_t sbq[$];
  int  checks = 0;
  int  errors = 0;

  function automatic ev_t mk(input logic [31:0] pc, rs, rt, imm, input logic [4:0] dest,
                             input logic [3:0] alu, input logic src, rw, mr, mw, ill);
    return {pc, rs, rt, imm, dest, alu, src, rw, mr, mw, ill};
  endfunction

  function automatic ev_t cur();
    return {ex_if.ex_pc, ex_if.ex_rs_data, ex_if.ex_rt_data, ex_if.ex_imm, ex_if.ex_dest,
            ex_if.ex_alu_op, ex_if.ex_alu_src_imm, ex_if.ex_reg_write, ex_if.ex_mem_read,
            ex_if.ex_mem_write, ex_if.ex_illegal};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ex_if.ex_valid && ex_if.ex_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transfer: got %h expected none", cur());
      end else begin
        sb_t  e;
        ev_t  m;
        e = sbq.pop_front();
        m = e.ctrl_only ? CTRL_MASK : '1;
        if ((cur() & m) !== (e.v & m)) begin
          errors++;
          $display("FAIL ex_transfer: got %h expected %h", cur() & m, e.v & m);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] instr, pc, d1, d2, input bit push,
                       input ev_t e, input bit co);
    bit acc;
    if (push) sbq.push_back('{v: e, ctrl_only: co});
    if_valid       = 1'b1;
    if_instr       = instr;
    if_pc          = pc;
    rf_read_data_1 = d1;
    rf_read_data_2 = d2;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = id_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("issue_timeout", 64'(acc), 64'd1);
    if_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
    rf_read_data_1 = '0; rf_read_data_2 = '0;
    wb_write_en = 1'b0; wb_write_dest = '0; wb_write_data = '0;
    ex_if.ex_ready = 1'b1;

    @(posedge clk); #1;
    chk("reset_valid", 64'(ex_if.ex_valid), 64'd0);
    chk("reset_fields", 64'(|cur()), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDI $8,$0,-5
    issue(32'h2008FFFB, 32'h100, 32'hDEADBEEF, 32'h22, 1'b1,
          mk(32'h100, 32'h0, 32'h22, 32'hFFFFFFFB, 5'd8, 4'd0, 1, 1, 0, 0, 0), 1'b0);

    // Reset in the middle of a stream: SLTI is loaded then wiped
    issue(32'h2862FFFF, 32'h104, 32'h3, 32'h4, 1'b0, '0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_valid", 64'(ex_if.ex_valid), 64'd0);
    chk("midreset_fields", 64'(|cur()), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postreset_ready", 64'(id_ready), 64'd1);
    @(posedge clk); #1;

    // rf addresses follow instr fields even without if_valid
    if_instr = 32'h8D090000;
    #1;
    chk("rf_addr_1", 64'(rf_read_addr_1), 64'd8);
    chk("rf_addr_2", 64'(rf_read_addr_2), 64'd9);

    // ADD $10,$9,$9 with same-cycle writeback of $9
    wb_write_en = 1'b1; wb_write_dest = 5'd9; wb_write_data = 32'h1234;
    issue(32'h01295020, 32'h200, 32'h0, 32'h0, 1'b1,
          mk(32'h200, 32'h1234, 32'h1234, 32'h5020, 5'd10, 4'd0, 0, 1, 0, 0, 0), 1'b0);
    // SUB $3,$1,$2 while writeback targets $0: no bypass
    wb_write_dest = 5'd0; wb_write_data = 32'hFFFF;
    issue(32'h00221822, 32'h204, 32'h5, 32'h7, 1'b1,
          mk(32'h204, 32'h5, 32'h7, 32'h1822, 5'd3, 4'd1, 0, 1, 0, 0, 0), 1'b0);
    wb_write_en = 1'b0;

    // LW $9,0($8) then ADD $10,$9,$1: one bubble
    issue(32'h8D090000, 32'h300, 32'h100, 32'h55, 1'b1,
          mk(32'h300, 32'h100, 32'h55, 32'h0, 5'd9, 4'd0, 1, 1, 1, 0, 0), 1'b0);
    if_valid = 1'b1; if_instr = 32'h01215020; if_pc = 32'h304;
    rf_read_data_1 = 32'h77; rf_read_data_2 = 32'h88;
    @(negedge clk);
    chk("hz_ready", 64'(id_ready), 64'd0);
    chk("hz_lw_valid", 64'(ex_if.ex_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bubble_valid", 64'(ex_if.ex_valid), 64'd0);
    chk("bubble_ready", 64'(id_ready), 64'd1);
    sbq.push_back('{v: mk(32'h304, 32'h77, 32'h88, 32'h5020, 5'd10, 4'd0, 0, 1, 0, 0, 0),
                    ctrl_only: 1'b0});
    @(posedge clk); #1;
    if_valid = 1'b0;

    // LW $9 then LUI $9: LUI reads no source, so no bubble
    issue(32'h8D090000, 32'h308, 32'h100, 32'h55, 1'b1,
          mk(32'h308, 32'h100, 32'h55, 32'h0, 5'd9, 4'd0, 1, 1, 1, 0, 0), 1'b0);
    if_valid = 1'b1; if_instr = 32'h3C091234; if_pc = 32'h30C;
    rf_read_data_1 = 32'h1; rf_read_data_2 = 32'h2;
    @(negedge clk);
    chk("lui_nohz_ready", 64'(id_ready), 64'd1);
    sbq.push_back('{v: mk(32'h30C, 32'h0, 32'h2, 32'h12340000, 5'd9, 4'd6, 1, 1, 0, 0, 0),
                    ctrl_only: 1'b0});
    @(posedge clk); #1;
    if_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure: ANDI $6,$7,0x8001 held three cycles, then flushed with ADDI pending
    ex_if.ex_ready = 1'b0;
    issue(32'h30E68001, 32'h400, 32'h1, 32'h2, 1'b0, '0, 1'b0);
    if_valid = 1'b1; if_instr = 32'h2008FFFB; if_pc = 32'h404;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", 64'(id_ready), 64'd0);
      chk("stall_hold", {ex_if.ex_valid, ex_if.ex_imm, ex_if.ex_dest, ex_if.ex_alu_op},
          {1'b1, 32'h8001, 5'd6, 4'd2});
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 64'(id_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0;
    chk("flush_valid", 64'(ex_if.ex_valid), 64'd0);
    ex_if.ex_ready = 1'b1;
    @(posedge clk); #1;

    // Illegal opcode, illegal funct, ORI to $0, SW, SLTI
    issue(32'hFC000000, 32'h500, 32'h0, 32'h0, 1'b1,
          mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'd0, 0, 0, 0, 0, 1), 1'b1);
    issue(32'h0000003F, 32'h504, 32'h0, 32'h0, 1'b1,
          mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'd0, 0, 0, 0, 0, 1), 1'b1);
    issue(32'h34000001, 32'h508, 32'h9, 32'h9, 1'b1,
          mk(32'h508, 32'h0, 32'h0, 32'h1, 5'd0, 4'd3, 1, 0, 0, 0, 0), 1'b0);
    issue(32'hAD090004, 32'h50C, 32'h1000, 32'hABCD, 1'b1,
          mk(32'h50C, 32'h1000, 32'hABCD, 32'h4, 5'd9, 4'd0, 1, 0, 0, 1, 0), 1'b0);
    issue(32'h2862FFFF, 32'h510, 32'h3, 32'h4, 1'b1,
          mk(32'h510, 32'h3, 32'h4, 32'hFFFFFFFF, 5'd2, 4'd4, 1, 1, 0, 0, 0), 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
